// File: rtl/wb_host_master.sv
// Wishbone classic single-transaction host master: valid/ready request in,
// one bus cycle with timeout, registered response held until consumed.
module wb_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_ready_nxt;
  logic             cyc_nxt, stb_nxt, we_nxt;
  logic [31:0]      adr_nxt, dat_o_nxt;
  logic [3:0]       sel_nxt;
  logic             rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [31:0]      rsp_dat_nxt;

  // Every output is a register; this block computes all their next values.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    req_ready_nxt   = req_ready;
    cyc_nxt         = wbm_cyc_o;
    stb_nxt         = wbm_stb_o;
    we_nxt          = wbm_we_o;
    adr_nxt         = wbm_adr_o;
    sel_nxt         = wbm_sel_o;
    dat_o_nxt       = wbm_dat_o;
    rsp_valid_nxt   = rsp_valid;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    rsp_dat_nxt     = rsp_dat;

    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (req_valid && req_ready) begin
          state_nxt     = BUS;
          req_ready_nxt = 1'b0;
          cnt_nxt       = '0;
          cyc_nxt       = 1'b1;
          stb_nxt       = 1'b1;
          we_nxt        = req_we;
          adr_nxt       = req_adr;
          sel_nxt       = req_sel;
          dat_o_nxt     = req_dat;
        end
      end
      BUS: begin
        // Priority: err, then ack, then timeout on the last allowed cycle.
        if (wbm_err_i || wbm_ack_i || (cnt == CNT_LAST)) begin
          state_nxt       = RESP;
          cyc_nxt         = 1'b0;
          stb_nxt         = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = wbm_err_i || !wbm_ack_i;
          rsp_timeout_nxt = !wbm_err_i && !wbm_ack_i;
          rsp_dat_nxt     = (!wbm_err_i && wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'd0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_sel_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_dat     <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      req_ready   <= req_ready_nxt;
      wbm_cyc_o   <= cyc_nxt;
      wbm_stb_o   <= stb_nxt;
      wbm_we_o    <= we_nxt;
      wbm_adr_o   <= adr_nxt;
      wbm_sel_o   <= sel_nxt;
      wbm_dat_o   <= dat_o_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      rsp_dat     <= rsp_dat_nxt;
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master with a 4-cycle timeout.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        ack, err;
  logic [31:0] dat_i;

  int n_checks = 0;
  int n_pass   = 0;

  wb_host_master #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_sel(req_sel), .req_dat(req_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o),
    .wbm_adr_o(adr_o), .wbm_sel_o(sel_o), .wbm_dat_o(dat_o),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_dat_i(dat_i)
  );

  always #5 clk = ~clk;

  // Offer a request (caller is 1 time unit after an edge with req_ready high).
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    req_we = w; req_adr = a; req_sel = s; req_dat = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Slave responder: terminates on strobe cycle ack_at (-1 = never); n = strobe cycles seen.
  task automatic slave(input int ack_at, input logic a_v, input logic e_v, input logic [31:0] rd, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stb) break;
      if (n == ack_at) begin ack = a_v; err = e_v; dat_i = rd; end
      else begin ack = 1'b0; err = 1'b0; dat_i = 32'hA5A5_A5A5; end
      n++;
      @(posedge clk); #1;
    end
    ack = 1'b0; err = 1'b0; dat_i = '0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL consume_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL consume_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if ({cyc, stb, rsp_valid, req_ready} !== 4'b0) $display("FAIL rst_ctrl: got %b want 0000", {cyc, stb, rsp_valid, req_ready}); else n_pass++;
    n_checks++; if ({adr_o, dat_o, sel_o, we_o} !== 69'd0) $display("FAIL rst_bus: got %h want 0", {adr_o, dat_o, sel_o, we_o}); else n_pass++;
    n_checks++; if ({rsp_dat, rsp_err, rsp_timeout} !== 34'd0) $display("FAIL rst_rsp: got %h want 0", {rsp_dat, rsp_err, rsp_timeout}); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_held_ready: got %b want 0", req_ready); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_write();
    int n;
    issue(1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF);
    n_checks++; if ({cyc, stb, req_ready} !== 3'b110) $display("FAIL wr_latency: got %b want 110", {cyc, stb, req_ready}); else n_pass++;
    n_checks++; if ({we_o, adr_o, sel_o, dat_o} !== {1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF})
      $display("FAIL wr_bus: got %h want %h", {we_o, adr_o, sel_o, dat_o}, {1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF}); else n_pass++;
    slave(2, 1'b1, 1'b0, 32'h5555_5555, n);
    n_checks++; if (n !== 3) $display("FAIL wr_stb_cycles: got %0d want 3", n); else n_pass++;
    n_checks++; if ({cyc, rsp_valid, rsp_err, rsp_timeout} !== 4'b0100) $display("FAIL wr_rsp_flags: got %b want 0100", {cyc, rsp_valid, rsp_err, rsp_timeout}); else n_pass++;
    n_checks++; if (rsp_dat !== 32'd0) $display("FAIL wr_rsp_dat: got %h want 0", rsp_dat); else n_pass++;
    consume();
  endtask

  task automatic test_read();
    int n;
    issue(1'b0, 32'h3000_0000, 4'hF, 32'h0);
    slave(0, 1'b1, 1'b0, 32'h1234_5678, n);
    n_checks++; if (n !== 1) $display("FAIL rd_stb_cycles: got %0d want 1", n); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL rd_rsp_flags: got %b want 10", {rsp_valid, rsp_err}); else n_pass++;
    n_checks++; if (rsp_dat !== 32'h1234_5678) $display("FAIL rd_rsp_dat: got %h want 12345678", rsp_dat); else n_pass++;
    consume();
  endtask

  task automatic test_error();
    int n;
    issue(1'b0, 32'h3000_0008, 4'h3, 32'h0);
    slave(0, 1'b1, 1'b1, 32'hFFFF_FFFF, n);
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) $display("FAIL err_flags: got %b want 110", {rsp_valid, rsp_err, rsp_timeout}); else n_pass++;
    n_checks++; if (rsp_dat !== 32'd0) $display("FAIL err_dat: got %h want 0", rsp_dat); else n_pass++;
    consume();
  endtask

  task automatic test_timeout();
    int n;
    issue(1'b0, 32'h3000_0010, 4'hF, 32'h0);
    slave(-1, 1'b0, 1'b0, 32'h0, n);
    n_checks++; if (n !== 4) $display("FAIL to_stb_cycles: got %0d want 4", n); else n_pass++;
    n_checks++; if ({cyc, rsp_valid, rsp_err, rsp_timeout} !== 4'b0111) $display("FAIL to_flags: got %b want 0111", {cyc, rsp_valid, rsp_err, rsp_timeout}); else n_pass++;
    n_checks++; if (rsp_dat !== 32'd0) $display("FAIL to_dat: got %h want 0", rsp_dat); else n_pass++;
    consume();
    issue(1'b0, 32'h3000_0014, 4'hF, 32'h0);
    slave(3, 1'b1, 1'b0, 32'h0BAD_F00D, n);
    n_checks++; if (n !== 4) $display("FAIL to_edge_cycles: got %0d want 4", n); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) $display("FAIL to_edge_flags: got %b want 100", {rsp_valid, rsp_err, rsp_timeout}); else n_pass++;
    n_checks++; if (rsp_dat !== 32'h0BAD_F00D) $display("FAIL to_edge_dat: got %h want 0badf00d", rsp_dat); else n_pass++;
    consume();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    issue(1'b0, 32'h3000_0020, 4'hF, 32'h0);
    slave(0, 1'b1, 1'b0, 32'hCAFE_0001, n);
    // Offer a new request and stray acks while the response is stalled.
    req_we = 1'b1; req_adr = 32'h3000_0024; req_sel = 4'hC; req_dat = 32'h7777_8888; req_valid = 1'b1;
    ack = 1'b1; dat_i = 32'h9999_9999;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({rsp_valid, rsp_err, rsp_timeout, req_ready, cyc, stb} !== 6'b100000 || rsp_dat !== 32'hCAFE_0001) bad++;
    end
    ack = 1'b0; dat_i = '0;
    n_checks++; if (bad !== 0) $display("FAIL bp_stable: got %0d bad cycles want 0", bad); else n_pass++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++; if ({rsp_valid, req_ready, stb} !== 3'b010) $display("FAIL bp_release: got %b want 010", {rsp_valid, req_ready, stb}); else n_pass++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if ({stb, we_o, adr_o} !== {2'b11, 32'h3000_0024}) $display("FAIL bp_next_req: got %h want %h", {stb, we_o, adr_o}, {2'b11, 32'h3000_0024}); else n_pass++;
    slave(1, 1'b1, 1'b0, 32'h0, n);
    n_checks++; if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'd0}) $display("FAIL bp_next_rsp: got %h want %h", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 32'd0}); else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid_bus();
    int bad;
    issue(1'b1, 32'h3000_0030, 4'hF, 32'h1111_2222);
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({cyc, stb, rsp_valid, req_ready} !== 4'b0000) $display("FAIL mid_rst_async: got %b want 0000", {cyc, stb, rsp_valid, req_ready}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      ack = (i == 1);
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || stb !== 1'b0) bad++;
    end
    ack = 1'b0;
    n_checks++; if (bad !== 0) $display("FAIL mid_rst_no_rsp: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0; req_dat = '0;
    rsp_ready = 1'b0; ack = 1'b0; err = 1'b0; dat_i = '0;
    test_reset();
    test_write();
    test_read();
    test_error();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles a bus cycle may wait for wbm_ack_i/wbm_err_i; legal range 1..65535.
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all logic rising-edge.
REQ-003 SHALL have port wb_rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high on a rising edge.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_adr  input  32  byte address.
REQ-008 SHALL have port req_sel  input  4  byte lane enables.
REQ-009 SHALL have port req_dat  input  32  write data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-012 SHALL have port rsp_dat  output  32  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err  output  1  bus error or timeout.
REQ-014 SHALL have port rsp_timeout  output  1  error was a timeout.
REQ-015 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-016 SHALL have ports wbm_adr_o  output  32, wbm_sel_o  output  4, wbm_dat_o  output  32  Wishbone address/lanes/write data.
REQ-017 SHALL have ports wbm_ack_i  input  1, wbm_err_i  input  1, wbm_dat_i  input  32  slave termination and read data.

Function
REQ-018 SHALL implement FSM states IDLE, BUS, RESP; exactly one active.
REQ-019 IDLE: req_ready=1, cyc/stb=0; on accepted request SHALL latch we/adr/sel/dat, clear timeout counter, go to BUS.
REQ-020 BUS: cyc=stb=1, req_ready=0; wbm_we_o/adr/sel/dat SHALL hold latched values, stable for the whole cycle.
REQ-021 First cycle of BUS SHALL be the edge after acceptance (1-cycle request-to-strobe latency).
REQ-022 In BUS, wbm_err_i=1 at an edge SHALL end the cycle: rsp_err=1, rsp_timeout=0, rsp_dat=0; go to RESP.
REQ-023 In BUS, wbm_ack_i=1 with wbm_err_i=0 SHALL end the cycle: rsp_err=0; rsp_dat=wbm_dat_i for reads, 0 for writes; go to RESP.
REQ-024 ack and err asserted together SHALL be treated as err.
REQ-025 Counter SHALL increment each BUS cycle without termination; when it reaches TIMEOUT_CYCLES without termination, cycle SHALL end with rsp_err=1, rsp_timeout=1, rsp_dat=0; go to RESP.
REQ-026 Termination on the same edge the counter would expire SHALL win over timeout.
REQ-027 cyc/stb SHALL deassert on the edge following termination (no back-to-back strobes; min one idle bus cycle between transactions).
REQ-028 RESP: rsp_valid=1, rsp_* stable until rsp_ready=1; then go to IDLE, rsp_valid=0.
REQ-029 req_ready SHALL be 0 in BUS and RESP; at most one outstanding transaction.
REQ-030 Acks/errs received outside BUS SHALL be ignored.

Reset
REQ-031 wb_rst_i high SHALL asynchronously force IDLE and: wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_sel_o=0, wbm_dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, rsp_timeout=0, counter=0; req_ready=0 while reset asserted, 1 from first edge after release.
REQ-032 Reset during BUS or RESP SHALL abort the transaction with no response generated.

Verification
REQ-033 Write: req adr=0x3000_0004, sel=0xF, dat=0xDEAD_BEEF, we=1; slave acks 2 cycles after stb -> cyc/stb high 3 cycles, rsp_valid with rsp_err=0, rsp_dat=0.
REQ-034 Read: adr=0x3000_0000, slave acks first stb cycle with wbm_dat_i=0x1234_5678 -> rsp_dat=0x1234_5678, rsp_err=0, stb high exactly 1 cycle.
REQ-035 Error: slave asserts ack and err same cycle -> rsp_err=1, rsp_timeout=0, rsp_dat=0.
REQ-036 Timeout: TIMEOUT_CYCLES=4, no slave response -> cyc drops after 4 stb cycles, rsp_err=1, rsp_timeout=1; ack on 4th cycle instead -> rsp_err=0.
REQ-037 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0, no new strobe; new request accepted only after rsp_ready pulse.
REQ-038 Reset mid-BUS: assert wb_rst_i between edges while stb=1 -> cyc/stb fall immediately (asynchronously), no rsp_valid after release.
